mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 4, giving the maximum number of cycles the fetch port waits while losing to the data port.
REQ-002 The ports SHALL be, one per line as name  direction  width  meaning:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- f_req_i  in  1  fetch request; held high with f_addr_i stable until f_gnt_o.
- f_addr_i  in  MEM_ADDR_SIZE  fetch address.
- f_gnt_o  out  1  fetch owns the memory this cycle.
- f_valid_o  out  1  one-cycle pulse; f_data_o is valid.
- f_data_o  out  3*`BYTE  the three bytes {addr+2, addr+1, addr}.
- d_req_i  in  1  data request; held high with d_we_i, d_addr_i and d_wdata_i stable until d_gnt_o.
- d_we_i  in  1  1 = byte write, 0 = read.
- d_addr_i  in  MEM_ADDR_SIZE  data address.
- d_wdata_i  in  `BYTE  write byte.
- d_gnt_o  out  1  data owns the memory this cycle.
- d_valid_o  out  1  one-cycle completion pulse for reads and writes.
- d_rdata_o  out  `BYTE  read byte, taken from the low byte of mem_rdata_i.
- mem_addr_o  out  MEM_ADDR_SIZE  memory address.
- mem_we_o  out  1  memory write enable.
- mem_wdata_o  out  `BYTE  memory write byte.
- mem_rdata_i  in  3*`BYTE  combinational 3-byte memory read data.

Function
REQ-003 The FSM SHALL have three states: IDLE, FETCH and DATA.
REQ-004 In FETCH and DATA the block SHALL drive mem_addr_o from the address captured at the IDLE decision, and SHALL assert the matching gnt for exactly that cycle.
REQ-005 In IDLE, gnt outputs SHALL be 0, mem_we_o SHALL be 0, and mem_addr_o SHALL be 0.
REQ-006 The latency SHALL be: request seen in IDLE at cycle N, gnt in cycle N+1, read data registered at the end of N+1, valid pulse in cycle N+2.
REQ-007 The valid pulse SHALL last one cycle, and f_data_o/d_rdata_o SHALL hold their values until the next completion on the same port.
REQ-008 mem_we_o SHALL be 1 only in DATA with the captured we=1; it SHALL be forced to 0 while rst_i is high.
REQ-009 A write SHALL also produce d_valid_o at N+2 and SHALL leave d_rdata_o unchanged.
REQ-010 From FETCH or DATA, if the other port requests, the FSM SHALL go directly to that port's state (back-to-back alternation, one transfer per cycle).
REQ-011 The request of the port granted in the current cycle SHALL be ignored for the next decision, so a port can never be granted twice in a row without an IDLE cycle.
REQ-012 Default arbitration SHALL be fixed priority with data over fetch.
REQ-013 A saturating starvation counter SHALL increment each cycle f_req_i is high and ungranted, and SHALL clear on f_gnt_o.
REQ-014 When the starvation counter is at or above STARVE_LIMIT, fetch SHALL win a simultaneous request.
REQ-015 The block SHALL pass addresses unmodified; wrap-around at 2**MEM_ADDR_SIZE is the memory's behaviour.
REQ-016 A request deasserted before its grant SHALL be dropped with no valid pulse.

Reset
REQ-017 While rst_i is high at a clock edge, the block SHALL set state to IDLE, starvation counter 0, f_valid_o and d_valid_o 0, f_data_o 0, d_rdata_o 0, and last-grant 0 (fetch).
REQ-018 A transaction in flight at reset SHALL be abandoned without a valid pulse.

Configuration
REQ-019 With MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: the port not granted most recently wins a simultaneous request, and the starvation counter and STARVE_LIMIT logic are removed.
REQ-020 Without MEM_ARB_RR_EN, REQ-012 to REQ-014 SHALL apply.

Structure
REQ-021 The state enum type mem_arb_state_t SHALL reside in nes_cpu_pkg, alongside the existing MEM_ADDR_SIZE.
REQ-022 A single sub-module, mem_arb_pick, SHALL hold the combinational winner selection (priority or round-robin); the FSM and registers SHALL remain in mem_arbiter.

Verification
REQ-023 The bench SHALL cover: f_req_i=1, f_addr_i=0x10, memory {0x12,0x11,0x10} -> f_gnt_o in cycle 1, f_valid_o in cycle 2 with f_data_o=0x121110.
REQ-024 The bench SHALL cover: d_req_i=1, d_we_i=1, d_addr_i=0x05, d_wdata_i=0xAB -> mem_we_o=1 and mem_addr_o=0x05 in cycle 1, d_valid_o in cycle 2, and a later read of 0x05 returns 0xAB.
REQ-025 The bench SHALL cover, with default config: both ports held requesting -> grant order D,F,D,F with no IDLE gap.
REQ-026 The bench SHALL cover: data requests every IDLE cycle while fetch waits -> fetch granted no later than STARVE_LIMIT=4 cycles after its request.
REQ-027 The bench SHALL cover: rst_i pulsed in a DATA write cycle -> mem_we_o=0 in that cycle, no d_valid_o, state IDLE.
REQ-028 The bench SHALL cover, with MEM_ARB_RR_EN and last grant = data: simultaneous requests -> fetch granted first.

Source files
------------

// File: rtl/nes_cpu_pkg.sv
// Shared CPU-side definitions: memory address width and the memory arbiter state type.
`ifndef BYTE
`define BYTE 8
`endif

package nes_cpu_pkg;

  localparam int MEM_ADDR_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } mem_arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data ports.
// MEM_ARB_RR_EN selects round-robin; otherwise data has priority unless fetch is starving.
module mem_arb_pick (
  input  logic f_req_i,
  input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_d_i,
`else
  input  logic starve_hit_i,
`endif
  output logic f_win_o,
  output logic d_win_o
);

  always_comb begin
    f_win_o = 1'b0;
    d_win_o = 1'b0;
    if (f_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
      // The port that was not granted most recently goes first.
      if (last_d_i) begin
        f_win_o = 1'b1;
      end else begin
        d_win_o = 1'b1;
      end
`else
      if (starve_hit_i) begin
        f_win_o = 1'b1;
      end else begin
        d_win_o = 1'b1;
      end
`endif
    end else begin
      f_win_o = f_req_i;
      d_win_o = d_req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter for a single combinational 3-byte memory.
// Build option MEM_ARB_RR_EN replaces data-priority + starvation guard with round-robin.
`ifndef BYTE
`define BYTE 8
`endif

module mem_arbiter
  import nes_cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     f_req_i,
  input  logic [MEM_ADDR_SIZE-1:0] f_addr_i,
  output logic                     f_gnt_o,
  output logic                     f_valid_o,
  output logic [3*`BYTE-1:0]       f_data_o,
  input  logic                     d_req_i,
  input  logic                     d_we_i,
  input  logic [MEM_ADDR_SIZE-1:0] d_addr_i,
  input  logic [`BYTE-1:0]         d_wdata_i,
  output logic                     d_gnt_o,
  output logic                     d_valid_o,
  output logic [`BYTE-1:0]         d_rdata_o,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
  output logic                     mem_we_o,
  output logic [`BYTE-1:0]         mem_wdata_o,
  input  logic [3*`BYTE-1:0]       mem_rdata_i,
  output mem_arb_state_t           dbg_state_o,
  output logic                     dbg_last_d_o
);

  // Handshake: a port raises req and holds its address/data stable until its gnt
  // cycle; gnt is high for exactly one cycle and valid pulses the cycle after gnt.

  mem_arb_state_t           state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0] addr_q, addr_d;
  logic                     we_q, we_d;
  logic [`BYTE-1:0]         wdata_q, wdata_d;
  logic                     f_valid_q, f_valid_d;
  logic [3*`BYTE-1:0]       f_data_q, f_data_d;
  logic                     d_valid_q, d_valid_d;
  logic [`BYTE-1:0]         d_rdata_q, d_rdata_d;
  logic                     last_d_q, last_d_d;

  logic f_eff, d_eff;
  logic f_win, d_win;

  // The port owning the memory this cycle cannot win the next decision.
  assign f_eff = f_req_i && (state_q != FETCH);
  assign d_eff = d_req_i && (state_q != DATA);

`ifdef MEM_ARB_RR_EN
  mem_arb_pick u_pick (
    .f_req_i  (f_eff),
    .d_req_i  (d_eff),
    .last_d_i (last_d_q),
    .f_win_o  (f_win),
    .d_win_o  (d_win)
  );
`else
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          starve_hit;

  assign starve_hit = (starve_q >= SW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (f_gnt_o) begin
      starve_d = '0;
    end else if (f_req_i && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  mem_arb_pick u_pick (
    .f_req_i      (f_eff),
    .d_req_i      (d_eff),
    .starve_hit_i (starve_hit),
    .f_win_o      (f_win),
    .d_win_o      (d_win)
  );
`endif

  // Next-state decision and request capture.
  always_comb begin
    state_d = IDLE;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (f_win) begin
          state_d = FETCH;
        end else if (d_win) begin
          state_d = DATA;
        end
      end
      FETCH: begin
        if (d_win) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (f_win) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == FETCH) begin
      addr_d = f_addr_i;
      we_d   = 1'b0;
    end else if (state_d == DATA) begin
      addr_d  = d_addr_i;
      we_d    = d_we_i;
      wdata_d = d_wdata_i;
    end
  end

  // Memory-side outputs are driven only while a port owns the memory.
  always_comb begin
    f_gnt_o     = 1'b0;
    d_gnt_o     = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    case (state_q)
      FETCH: begin
        f_gnt_o    = 1'b1;
        mem_addr_o = addr_q;
      end
      DATA: begin
        d_gnt_o    = 1'b1;
        mem_addr_o = addr_q;
        mem_we_o   = we_q && !rst_i;
        if (we_q) begin
          mem_wdata_o = wdata_q;
        end
      end
      default: ;
    endcase
  end

  // Completion: read data is registered at the end of the grant cycle.
  always_comb begin
    f_valid_d = (state_q == FETCH);
    d_valid_d = (state_q == DATA);
    f_data_d  = f_data_q;
    d_rdata_d = d_rdata_q;
    last_d_d  = last_d_q;
    if (state_q == FETCH) begin
      f_data_d = mem_rdata_i;
      last_d_d = 1'b0;
    end
    if (state_q == DATA) begin
      last_d_d = 1'b1;
      if (!we_q) begin
        d_rdata_d = mem_rdata_i[`BYTE-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      f_valid_q <= 1'b0;
      f_data_q  <= '0;
      d_valid_q <= 1'b0;
      d_rdata_q <= '0;
      last_d_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      f_valid_q <= f_valid_d;
      f_data_q  <= f_data_d;
      d_valid_q <= d_valid_d;
      d_rdata_q <= d_rdata_d;
      last_d_q  <= last_d_d;
    end
  end

  assign f_valid_o    = f_valid_q;
  assign f_data_o     = f_data_q;
  assign d_valid_o    = d_valid_q;
  assign d_rdata_o    = d_rdata_q;
  assign dbg_state_o  = state_q;
  assign dbg_last_d_o = last_d_q;

endmodule
